// File: rtl/timer_ctrl_pkg.sv
// Shared types and constants for the timer sequencing controller.
package timer_ctrl_pkg;

    localparam int unsigned TC_WIDTH = 4;
    localparam logic [TC_WIDTH-1:0] TC_DEF_PERIOD = 4'hF;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_RUN    = 2'd1,
        S_PAUSED = 2'd2,
        S_DONE   = 2'd3
    } state_e;

    typedef enum logic {
        MODE_ONESHOT  = 1'b0,
        MODE_PERIODIC = 1'b1
    } mode_e;

    // A run is in progress while counting or paused.
    function automatic logic is_busy(input state_e s);
        return (s == S_RUN) || (s == S_PAUSED);
    endfunction

endpackage

// File: rtl/timer_ctrl_if.sv
// Control/status bundle between the controlling logic and the timer.
interface timer_ctrl_if import timer_ctrl_pkg::*; #(
    parameter int unsigned WIDTH = TC_WIDTH
);
    logic             start;
    logic             stop;
    logic             pause;
    logic             periodic;
    logic [WIDTH-1:0] period;
    logic [WIDTH-1:0] count;
    logic             busy;
    logic             paused;
    logic             done;

    modport master (
        output start, stop, pause, periodic, period,
        input  count, busy, paused, done
    );

    modport slave (
        input  start, stop, pause, periodic, period,
        output count, busy, paused, done
    );
endinterface

// File: rtl/timer_ctrl_hold_counter.sv
// Up-counter with synchronous clear and hold; clear beats increment.
module hold_counter #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             hold,
    output logic [WIDTH-1:0] q
);

    // Count register: clear to zero, else step unless held.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            q <= '0;
        end else if (!hold) begin
            q <= q + WIDTH'(1);
        end
    end

endmodule

// File: rtl/timer_ctrl.sv
// Start/stop/pause sequencer for a hold-style counter, one-shot or periodic.
module timer_ctrl import timer_ctrl_pkg::*; #(
    parameter int unsigned      WIDTH      = TC_WIDTH,
    parameter logic [WIDTH-1:0] DEF_PERIOD = WIDTH'(TC_DEF_PERIOD)
) (
    input  logic         clk,
    input  logic         rst,
    timer_ctrl_if.slave  bus
);

    state_e           state;
    state_e           state_nxt;
    logic [WIDTH-1:0] period_q;
    mode_e            mode_q;
    logic             done_q;
    logic             done_nxt;
    logic             load;
    logic             clr;
    logic             hold;
    logic             tc;
    logic [WIDTH-1:0] count;

    // Terminal count is only meaningful while actively counting.
    assign tc = (state == S_RUN) && (count == period_q) && !bus.pause;

    // State, latched run parameters and done pulse register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_IDLE;
            period_q <= DEF_PERIOD;
            mode_q   <= MODE_ONESHOT;
            done_q   <= 1'b0;
        end else begin
            state  <= state_nxt;
            done_q <= done_nxt;
            if (load) begin
                period_q <= bus.period;
                mode_q   <= mode_e'(bus.periodic);
            end
        end
    end

    // Next state and counter commands; stop overrides everything but reset.
    always_comb begin
        state_nxt = state;
        done_nxt  = 1'b0;
        load      = 1'b0;
        clr       = 1'b0;
        hold      = 1'b1;
        if (bus.stop) begin
            state_nxt = S_IDLE;
            clr       = 1'b1;
        end else begin
            case (state)
                S_IDLE: begin
                    if (bus.start) begin
                        state_nxt = S_RUN;
                        clr       = 1'b1;
                        load      = 1'b1;
                    end
                end
                S_RUN: begin
                    if (tc) begin
                        done_nxt = 1'b1;
                        if (mode_q == MODE_PERIODIC) begin
                            clr = 1'b1;
                        end else begin
                            state_nxt = S_DONE;
                        end
                    end else if (bus.pause) begin
                        state_nxt = S_PAUSED;
                    end else begin
                        hold = 1'b0;
                    end
                end
                S_PAUSED: begin
                    if (!bus.pause) begin
                        state_nxt = S_RUN;
                    end
                end
                S_DONE: begin
                    state_nxt = S_IDLE;
                end
                default: begin
                    state_nxt = S_IDLE;
                end
            endcase
        end
    end

    hold_counter #(.WIDTH(WIDTH)) u_cnt (
        .clk  (clk),
        .rst  (rst),
        .clr  (clr),
        .hold (hold),
        .q    (count)
    );

    assign bus.count  = count;
    assign bus.busy   = is_busy(state);
    assign bus.paused = (state == S_PAUSED);
    assign bus.done   = done_q;

endmodule

// File: tb/tb_timer_ctrl.sv
// Directed vector bench for timer_ctrl.
module tb_timer_ctrl;

    logic clk;
    logic rst;

    timer_ctrl_if #(.WIDTH(4)) bus ();

    timer_ctrl #(.WIDTH(4), .DEF_PERIOD(4'hF)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic       rst;
        logic       start;
        logic       stop;
        logic       pause;
        logic       periodic;
        logic [3:0] period;
        logic [3:0] ec;
        logic       eb;
        logic       ep;
        logic       ed;
    } vec_t;

    vec_t tbl[$];
    int   total;
    int   bad;

    function automatic void add(input logic r, input logic s, input logic sp,
                                input logic pa, input logic pe, input logic [3:0] per,
                                input logic [3:0] ec, input logic eb, input logic ep,
                                input logic ed);
        vec_t x;
        x.rst = r; x.start = s; x.stop = sp; x.pause = pa; x.periodic = pe;
        x.period = per; x.ec = ec; x.eb = eb; x.ep = ep; x.ed = ed;
        tbl.push_back(x);
    endfunction

    // Drive one vector, clock it in, then check outputs 1ns after the edge.
    task automatic apply(input vec_t x, input string name);
        rst          = x.rst;
        bus.start    = x.start;
        bus.stop     = x.stop;
        bus.pause    = x.pause;
        bus.periodic = x.periodic;
        bus.period   = x.period;
        @(posedge clk);
        #1;
        total++;
        if (bus.count !== x.ec || bus.busy !== x.eb || bus.paused !== x.ep || bus.done !== x.ed) begin
            bad++;
            $display("FAIL %s: got count=%0d busy=%0b paused=%0b done=%0b, want count=%0d busy=%0b paused=%0b done=%0b",
                     name, bus.count, bus.busy, bus.paused, bus.done, x.ec, x.eb, x.ep, x.ed);
        end
    endtask

    task automatic step(input logic s, input logic sp, input logic pa, input logic pe,
                        input logic [3:0] per, input logic [3:0] ec, input logic eb,
                        input logic ep, input logic ed, input string name);
        vec_t x;
        x.rst = 1'b0; x.start = s; x.stop = sp; x.pause = pa; x.periodic = pe;
        x.period = per; x.ec = ec; x.eb = eb; x.ep = ep; x.ed = ed;
        apply(x, name);
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst = 1'b1; bus.start = 0; bus.stop = 0; bus.pause = 0; bus.periodic = 0; bus.period = 0;

        // T1: reset, then one-shot period 5
        add(1,0,0,0,0,4'd5, 4'd0,0,0,0);
        add(0,1,0,0,0,4'd5, 4'd0,1,0,0);
        for (int i = 1; i <= 5; i++) add(0,0,0,0,0,4'd5, 4'(i),1,0,0);
        add(0,0,0,0,0,4'd5, 4'd5,0,0,1);
        add(0,0,0,0,0,4'd5, 4'd5,0,0,0);
        // T2: periodic period 3 for 12 cycles, then stop
        add(0,1,0,0,1,4'd3, 4'd0,1,0,0);
        for (int n = 1; n <= 12; n++) add(0,0,0,0,1,4'd3, 4'(n % 4),1,0,(n % 4) == 0);
        add(0,0,1,0,1,4'd3, 4'd0,0,0,0);
        // T3: pause at count 2 for 3 cycles
        add(0,1,0,0,0,4'd5, 4'd0,1,0,0);
        add(0,0,0,0,0,4'd5, 4'd1,1,0,0);
        add(0,0,0,0,0,4'd5, 4'd2,1,0,0);
        for (int i = 0; i < 3; i++) add(0,0,0,1,0,4'd5, 4'd2,1,1,0);
        add(0,0,0,0,0,4'd5, 4'd2,1,0,0);
        for (int i = 3; i <= 5; i++) add(0,0,0,0,0,4'd5, 4'(i),1,0,0);
        add(0,0,0,0,0,4'd5, 4'd5,0,0,1);
        add(0,0,0,0,0,4'd5, 4'd5,0,0,0);
        add(0,0,0,1,0,4'd5, 4'd5,0,0,0);
        // T4: stop with start and pause at count 4
        add(0,1,0,0,0,4'd9, 4'd0,1,0,0);
        for (int i = 1; i <= 4; i++) add(0,0,0,0,0,4'd9, 4'(i),1,0,0);
        add(0,1,1,1,0,4'd9, 4'd0,0,0,0);
        add(0,0,0,0,0,4'd9, 4'd0,0,0,0);
        // stop while paused
        add(0,1,0,0,0,4'd9, 4'd0,1,0,0);
        add(0,0,0,0,0,4'd9, 4'd1,1,0,0);
        add(0,0,0,1,0,4'd9, 4'd1,1,1,0);
        add(0,0,1,1,0,4'd9, 4'd0,0,0,0);
        // stop on the terminal-count edge suppresses done
        add(0,1,0,0,0,4'd1, 4'd0,1,0,0);
        add(0,0,0,0,0,4'd1, 4'd1,1,0,0);
        add(0,0,1,0,0,4'd1, 4'd0,0,0,0);
        // T5: period 0 one-shot, start held through DONE is ignored
        add(0,1,0,0,0,4'd0, 4'd0,1,0,0);
        add(0,1,0,0,0,4'd0, 4'd0,0,0,1);
        add(0,1,0,0,0,4'd0, 4'd0,0,0,0);
        add(0,1,0,0,0,4'd0, 4'd0,1,0,0);
        add(0,0,0,0,0,4'd0, 4'd0,0,0,1);
        add(0,0,0,0,0,4'd0, 4'd0,0,0,0);
        // period 0 periodic: done every cycle
        add(0,1,0,0,1,4'd0, 4'd0,1,0,0);
        add(0,0,0,0,1,4'd0, 4'd0,1,0,1);
        add(0,0,0,0,1,4'd0, 4'd0,1,0,1);
        add(0,0,1,0,1,4'd0, 4'd0,0,0,0);
        // start/periodic/period changes mid-run are ignored
        add(0,1,0,0,0,4'd3, 4'd0,1,0,0);
        add(0,1,0,0,1,4'd1, 4'd1,1,0,0);
        add(0,0,0,0,1,4'd1, 4'd2,1,0,0);
        add(0,0,0,0,1,4'd1, 4'd3,1,0,0);
        add(0,0,0,0,1,4'd1, 4'd3,0,0,1);
        add(0,0,0,0,1,4'd1, 4'd3,0,0,0);

        for (int i = 0; i < tbl.size(); i++) apply(tbl[i], $sformatf("vec%0d", i));

        // T5b: full-range period, no wrap in one-shot
        step(1,0,0,0,4'hF, 4'd0,1,0,0, "full_start");
        for (int i = 1; i <= 15; i++) step(0,0,0,0,4'hF, 4'(i),1,0,0, $sformatf("full_c%0d", i));
        step(0,0,0,0,4'hF, 4'd15,0,0,1, "full_done");
        step(0,0,0,0,4'hF, 4'd15,0,0,0, "full_hold");

        // T6: period change mid-run, then reset at count 6
        step(1,0,0,0,4'd9, 4'd0,1,0,0, "rst_start");
        for (int i = 1; i <= 6; i++) step(0,0,0,0,(i >= 3) ? 4'd2 : 4'd9, 4'(i),1,0,0, $sformatf("rst_c%0d", i));
        begin
            vec_t r;
            r = '0;
            r.rst = 1'b1; r.period = 4'd2; r.pause = 1'b1;
            apply(r, "rst_mid");
        end
        step(0,0,0,0,4'd2, 4'd0,0,0,0, "rst_idle");

        // separate run: latched 9 governs tc despite period=2 periodic=1
        step(1,0,0,0,4'd9, 4'd0,1,0,0, "latch_start");
        for (int i = 1; i <= 9; i++) step(0,0,0,1'b1,4'd2, 4'(i),1,0,0, $sformatf("latch_c%0d", i));
        step(0,0,0,1,4'd2, 4'd9,0,0,1, "latch_done");
        step(0,0,0,1,4'd2, 4'd9,0,0,0, "latch_idle");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
